pc_sequencer: RTL and testbench

//  Program-counter and fetch/execute sequencer for the 8-bit core; drives instruction-ROM address, consumes ALU rslt.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/pc_sequencer_sat_counter.sv | 26 ++
 rtl/pc_sequencer.sv | 94 +++++++++
 tb/tb_pc_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode and sequencer-state encodings shared by the ALU and the PC sequencer.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_ADD,
      ALU_XOR,
      ALU_BNE,
      ALU_LS,
      ALU_RS,
      ALU_LW,
      ALU_STR = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      EXEC,
      HALT
   } seq_state_t;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and two-cycle fetch/execute sequencer with start/done handshake
// and a saturating retired-instruction count.
module pc_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned PC_W     = 10,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned START_PC = 0,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              halt,
   input  alu_op_t           alu_cmd,
   input  logic [DATA_W-1:0] alu_rslt,
   output logic [PC_W-1:0]   prog_ctr,
   output logic              exec_en,
   output logic              done,
   output logic [CNT_W-1:0]  instr_cnt
);

   seq_state_t        r_state;
   logic [PC_W-1:0]   r_pc;
   logic              r_exec_en;
   logic              r_done;

   logic              w_start_ok;
   logic              w_taken;
   logic              w_inc;
   logic [PC_W-1:0]   w_offset;
   logic [PC_W-1:0]   w_pc_next;

   assign w_start_ok = start && ((r_state == IDLE) || (r_state == HALT));
   assign w_inc      = (r_state == EXEC);
   // A zero result means the BNE operands were equal, so the branch is not taken.
   assign w_taken    = (alu_cmd == ALU_BNE) && (alu_rslt != '0);
   assign w_offset   = PC_W'($signed(alu_rslt));
   assign w_pc_next  = r_pc + (w_taken ? w_offset : PC_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_pc      <= PC_W'(START_PC);
         r_exec_en <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            IDLE, HALT: begin
               if (start) begin
                  r_state   <= FETCH;
                  r_pc      <= PC_W'(START_PC);
                  r_exec_en <= 1'b0;
                  r_done    <= 1'b0;
               end
            end
            FETCH: begin
               r_state   <= EXEC;
               r_exec_en <= 1'b1;
            end
            EXEC: begin
               r_exec_en <= 1'b0;
               if (halt) begin
                  r_state <= HALT;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= FETCH;
                  r_pc    <= w_pc_next;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_exec_en <= 1'b0;
               r_done    <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_instr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_start_ok),
      .inc   (w_inc),
      .cnt   (instr_cnt)
   );

   assign prog_ctr = r_pc;
   assign exec_en  = r_exec_en;
   assign done     = r_done;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: one wide-counter and one 4-bit-counter sequencer share all stimulus.
module tb_pc_sequencer;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        halt = 1'b0;
   alu_op_t     alu_cmd = ALU_AND;
   logic [7:0]  alu_rslt = '0;

   logic [9:0]  pc_a, pc_b;
   logic        ex_a, ex_b, dn_a, dn_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;

   pc_sequencer #(.PC_W(10), .DATA_W(8), .START_PC(0), .CNT_W(16)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .alu_cmd(alu_cmd),
      .alu_rslt(alu_rslt), .prog_ctr(pc_a), .exec_en(ex_a), .done(dn_a), .instr_cnt(cnt_a));

   pc_sequencer #(.PC_W(10), .DATA_W(8), .START_PC(0), .CNT_W(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .alu_cmd(alu_cmd),
      .alu_rslt(alu_rslt), .prog_ctr(pc_b), .exec_en(ex_b), .done(dn_b), .instr_cnt(cnt_b));

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] pc;
      logic       exec_en;
      logic       done;
      int         cnt;
      string      name;
   } exp_t;

   typedef struct {
      alu_op_t    cmd;
      logic [7:0] rslt;
      logic       hlt;
      logic [9:0] pc;
   } vec_t;

   exp_t        sbq[$];
   vec_t        tbl[17];
   int          n_cmp = 0;
   int          n_err = 0;
   int          m_cnt = 0;
   int unsigned edges = 0;
   int unsigned e0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edges++;
   endtask

   task automatic push(input logic [9:0] pc, input logic ex, input logic dn, input string nm);
      exp_t e;
      e.pc = pc; e.exec_en = ex; e.done = dn; e.cnt = m_cnt; e.name = nm;
      sbq.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      int   sat;
      if (sbq.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sbq.pop_front();
         sat = (e.cnt > 15) ? 15 : e.cnt;
         chk({e.name, "_pc_a"},  16'(pc_a),  16'(e.pc));
         chk({e.name, "_pc_b"},  16'(pc_b),  16'(e.pc));
         chk({e.name, "_ex_a"},  16'(ex_a),  16'(e.exec_en));
         chk({e.name, "_ex_b"},  16'(ex_b),  16'(e.exec_en));
         chk({e.name, "_dn_a"},  16'(dn_a),  16'(e.done));
         chk({e.name, "_dn_b"},  16'(dn_b),  16'(e.done));
         chk({e.name, "_cnt16"}, cnt_a,      16'(e.cnt));
         chk({e.name, "_cnt4"},  16'(cnt_b), 16'(sat));
      end
   endtask

   task automatic wait_exec(input string nm);
      int k = 0;
      while (!ex_a && k < 8) begin
         step();
         k++;
      end
      if (!ex_a) begin
         n_cmp++; n_err++;
         $display("FAIL %s_wait_exec: got exec_en=0 expected exec_en=1 within 8 cycles", nm);
      end
   endtask

   task automatic do_start(input string nm);
      start = 1'b1;
      m_cnt = 0;
      push(10'd0, 1'b0, 1'b0, nm);
      step();
      start = 1'b0;
      pop_check();
   endtask

   task automatic run_instr(input alu_op_t c, input logic [7:0] r, input logic h,
                            input logic [9:0] exp_pc, input string nm);
      wait_exec(nm);
      alu_cmd  = c;
      alu_rslt = r;
      halt     = h;
      m_cnt++;
      push(exp_pc, 1'b0, h, nm);
      step();
      pop_check();
      halt     = 1'b0;
      alu_cmd  = ALU_AND;
      alu_rslt = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl = '{
         '{ALU_ADD, 8'h00, 1'b0, 10'd1},
         '{ALU_XOR, 8'hFF, 1'b0, 10'd2},
         '{ALU_LW,  8'h05, 1'b0, 10'd3},
         '{ALU_STR, 8'h80, 1'b0, 10'd4},
         '{ALU_AND, 8'h00, 1'b0, 10'd5},
         '{ALU_BNE, 8'hFD, 1'b0, 10'd2},
         '{ALU_LS,  8'h01, 1'b0, 10'd3},
         '{ALU_RS,  8'h02, 1'b0, 10'd4},
         '{ALU_BNE, 8'h00, 1'b0, 10'd5},
         '{ALU_BNE, 8'h00, 1'b0, 10'd6},
         '{ALU_BNE, 8'h7F, 1'b0, 10'd133},
         '{ALU_BNE, 8'h80, 1'b0, 10'd5},
         '{ALU_BNE, 8'hFB, 1'b0, 10'd0},
         '{ALU_BNE, 8'hFF, 1'b0, 10'd1023},
         '{ALU_ADD, 8'h00, 1'b0, 10'd0},
         '{ALU_BNE, 8'h09, 1'b0, 10'd9},
         '{ALU_BNE, 8'h04, 1'b1, 10'd9}
      };

      // Reset values and IDLE hold
      #1;
      chk("rst_pc",   16'(pc_a), 16'd0);
      chk("rst_ex",   16'(ex_a), 16'd0);
      chk("rst_done", 16'(dn_a), 16'd0);
      chk("rst_cnt",  cnt_a,     16'd0);
      step(); step();
      rst_n = 1'b1;
      m_cnt = 0;
      push(10'd0, 1'b0, 1'b0, "idle_hold");
      step(); step();
      pop_check();

      // Straight-line program, halt on the fourth instruction
      do_start("t1_start");
      e0 = edges;
      run_instr(ALU_ADD, 8'h00, 1'b0, 10'd1, "t1_i0");
      run_instr(ALU_ADD, 8'h00, 1'b0, 10'd2, "t1_i1");
      run_instr(ALU_ADD, 8'h00, 1'b0, 10'd3, "t1_i2");
      run_instr(ALU_ADD, 8'h00, 1'b1, 10'd3, "t1_halt");
      chk("t1_cycles_to_done", 16'(edges - e0), 16'd8);
      push(10'd3, 1'b0, 1'b1, "halt_hold");
      step(); step(); step();
      pop_check();

      // Start held high across HALT->FETCH restarts exactly once
      start = 1'b1;
      m_cnt = 0;
      push(10'd0, 1'b0, 1'b0, "t5_restart");
      step();
      pop_check();
      run_instr(ALU_ADD, 8'h00, 1'b0, 10'd1, "t5_held");
      start = 1'b0;

      // Start pulses during FETCH and EXEC are ignored
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t5_fetch_ign_ex", 16'(ex_a), 16'd1);
      chk("t5_fetch_ign_pc", 16'(pc_a), 16'd1);
      start = 1'b1;
      run_instr(ALU_ADD, 8'h00, 1'b0, 10'd2, "t5_exec_ign");
      start = 1'b0;
      run_instr(ALU_ADD, 8'h00, 1'b1, 10'd2, "t5_halt");

      // Table-driven branch, wrap and halt-priority vectors
      do_start("tbl_start");
      for (int i = 0; i < 17; i++) begin
         run_instr(tbl[i].cmd, tbl[i].rslt, tbl[i].hlt, tbl[i].pc, $sformatf("vec%0d", i));
      end

      // Counter saturation, then reset in the middle of EXEC
      do_start("t6_start");
      for (int i = 0; i < 20; i++) begin
         run_instr(ALU_ADD, 8'h00, 1'b0, 10'(i + 1), $sformatf("t6_i%0d", i));
      end
      wait_exec("t6_pre_rst");
      alu_cmd = ALU_BNE;
      alu_rslt = 8'h10;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_pc_a",  16'(pc_a),  16'd0);
      chk("t6_rst_pc_b",  16'(pc_b),  16'd0);
      chk("t6_rst_ex",    16'(ex_a),  16'd0);
      chk("t6_rst_done",  16'(dn_a),  16'd0);
      chk("t6_rst_cnt16", cnt_a,      16'd0);
      chk("t6_rst_cnt4",  16'(cnt_b), 16'd0);
      alu_cmd = ALU_AND;
      alu_rslt = '0;
      step();
      rst_n = 1'b1;
      m_cnt = 0;
      push(10'd0, 1'b0, 1'b0, "t6_post_rst_idle");
      step(); step();
      pop_check();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
